if_queue: RTL and testbench

- Instruction buffer between the Fetch stage and the Decode stage of the RISC-V pipeline.
- Captures {pc, pcplus4, instr} tuples produced by Fetch and presents them in order to Decode over a valid/ready handshake.
- Absorbs Decode back-pressure: f_ready drives the PC hold/stall hook.
- Discards all buffered instructions on a control-flow redirect (flush, driven from pcsrc).

---
 rtl/if_queue.sv | 127 ++++++++++++
 tb/tb_if_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/if_queue.sv
// ---------------------------------------------------------------------------
// if_queue
// Instruction buffer between Fetch and Decode. Fetch pushes {pc, pcplus4,
// instr} tuples, and Decode receives them in the same order over a
// valid/ready handshake. A redirect (flush) discards everything buffered.
//
// Parameters
//   DEPTH  number of entries (power of two, >= 2)
//   NOP    instruction shown on d_instr while the queue is empty
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      control-flow redirect; queue is empty after the next edge
//   f_valid    Fetch presents a tuple
//   f_ready    queue not full (feeds the PC hold/stall hook)
//   f_pc       fetched PC
//   f_pcplus4  fetched PC+4
//   f_instr    fetched instruction word
//   d_valid    head entry valid
//   d_ready    Decode consumes the head this cycle
//   d_pc       head PC (0 when empty)
//   d_pcplus4  head PC+4 (0 when empty)
//   d_instr    head instruction (NOP when empty)
//   count      number of occupied entries
// ---------------------------------------------------------------------------
module if_queue #(
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         f_valid,
    output logic                         f_ready,
    input  logic [31:0]                  f_pc,
    input  logic [31:0]                  f_pcplus4,
    input  logic [31:0]                  f_instr,
    output logic                         d_valid,
    input  logic                         d_ready,
    output logic [31:0]                  d_pc,
    output logic [31:0]                  d_pcplus4,
    output logic [31:0]                  d_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [95:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic [95:0]   head_s;

    // Handshake qualifiers come only from registered occupancy, so f_ready
    // has no path from d_ready: a full queue refuses a push even while it pops.
    always_comb begin
        full_s  = (count_r == CW'(DEPTH));
        empty_s = (count_r == CW'(0));
        push_s  = f_valid & ~full_s;
        pop_s   = d_ready & ~empty_s;
    end

    // Pointer and occupancy update; reset beats flush, flush drops any
    // handshake happening in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else if (flush) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are deliberately not reset, and nothing is
    // written during a reset or flush cycle.
    always_ff @(posedge clk) begin
        if (push_s && !rst && !flush) begin
            mem_r[wr_ptr_r] <= {f_pc, f_pcplus4, f_instr};
        end
    end

    // Head presentation: stored tuple when valid, a harmless NOP bubble otherwise.
    always_comb begin
        head_s = mem_r[rd_ptr_r];
        if (empty_s) begin
            d_pc      = 32'h00000000;
            d_pcplus4 = 32'h00000000;
            d_instr   = NOP;
        end else begin
            d_pc      = head_s[95:64];
            d_pcplus4 = head_s[63:32];
            d_instr   = head_s[31:0];
        end
    end

    assign f_ready = ~full_s;
    assign d_valid = ~empty_s;
    assign count   = count_r;

endmodule

// File: tb/tb_if_queue.sv
module tb_if_queue;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] NOPI = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst, flush, f_valid, f_ready, d_valid, d_ready;
    logic [31:0]   f_pc, f_pcplus4, f_instr, d_pc, d_pcplus4, d_instr;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    if_queue #(.DEPTH(DEPTH), .NOP(NOPI)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .f_valid(f_valid), .f_ready(f_ready),
        .f_pc(f_pc), .f_pcplus4(f_pcplus4), .f_instr(f_instr),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_pc(d_pc), .d_pcplus4(d_pcplus4), .d_instr(d_instr),
        .count(count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a plain queue of tuples plus a log of what Decode took.
    logic [95:0] model_q[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_p4[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int          n;
        logic [95:0] h;
        int          w, r, diff;
        logic        inv_ok;
        n = model_q.size();
        chk({tag, "_count"},   32'(count),   32'(n));
        chk({tag, "_f_ready"}, 32'(f_ready), (n != DEPTH) ? 32'd1 : 32'd0);
        chk({tag, "_d_valid"}, 32'(d_valid), (n != 0) ? 32'd1 : 32'd0);
        if (n > 0) begin
            h = model_q[0];
            chk({tag, "_d_pc"},      d_pc,      h[95:64]);
            chk({tag, "_d_pcplus4"}, d_pcplus4, h[63:32]);
            chk({tag, "_d_instr"},   d_instr,   h[31:0]);
        end else begin
            chk({tag, "_d_pc"},      d_pc,      32'h0);
            chk({tag, "_d_pcplus4"}, d_pcplus4, 32'h0);
            chk({tag, "_d_instr"},   d_instr,   NOPI);
        end
        // Occupancy invariant relating pointers and count.
        w    = int'(dut.wr_ptr_r);
        r    = int'(dut.rd_ptr_r);
        diff = (w - r + DEPTH) % DEPTH;
        if (int'(count) == DEPTH) inv_ok = (w == r);
        else                      inv_ok = (diff == int'(count)) && (int'(count) < DEPTH);
        chk({tag, "_ptr_inv"}, 32'(inv_ok), 32'd1);
    endtask

    // Drive one cycle, advance the model across the edge, settle past the edge.
    task automatic cycle(input logic r, input logic fl, input logic fv,
                         input logic [31:0] pc, input logic [31:0] p4,
                         input logic [31:0] ins, input logic dr);
        bit          push, pop;
        logic [95:0] h;
        rst = r; flush = fl; f_valid = fv; d_ready = dr;
        f_pc = pc; f_pcplus4 = p4; f_instr = ins;
        push = fv && (model_q.size() < DEPTH);
        pop  = dr && (model_q.size() > 0);
        @(posedge clk);
        if (r || fl) begin
            model_q.delete();
        end else begin
            if (pop) begin
                h = model_q.pop_front();
                got_pc.push_back(h[95:64]);
                got_p4.push_back(h[63:32]);
            end
            if (push) model_q.push_back({pc, p4, ins});
        end
        #1;
    endtask

    initial begin
        int idx;
        rst = 1'b1; flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
        f_pc = 32'h0; f_pcplus4 = 32'h0; f_instr = 32'h0;

        // Reset with Fetch presenting a tuple: nothing captured.
        cycle(1'b1, 1'b0, 1'b1, 32'h0, 32'h4, 32'h00500093, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h0, 32'h4, 32'h00500093, 1'b0);
        check_all("reset");
        chk("reset_instr_const", d_instr, 32'h00000013);

        // Pass-through: visible the cycle after the push, then popped.
        cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 32'h00500093, 1'b1);
        check_all("pt_push");
        chk("pt_instr_const", d_instr, 32'h00500093);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        check_all("pt_pop");

        // Fill to full, third push ignored, then drain.
        cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 32'h11111111, 1'b0);
        check_all("fill1");
        cycle(1'b0, 1'b0, 1'b1, 32'h4, 32'h8, 32'h22222222, 1'b0);
        check_all("fill2");
        chk("fill_f_ready_const", 32'(f_ready), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h8, 32'hC, 32'h33333333, 1'b0);
        check_all("fill3_ignored");
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        check_all("drain1");
        chk("drain1_pc_const", d_pc, 32'h4);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        check_all("drain2");

        // Full with simultaneous pop: push dropped, pop taken.
        cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 32'h44444444, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h4, 32'h8, 32'h55555555, 1'b0);
        check_all("fp_full");
        cycle(1'b0, 1'b0, 1'b1, 32'h8, 32'hC, 32'h66666666, 1'b1);
        check_all("fp_poppush");
        chk("fp_count_const", 32'(count), 32'd1);
        chk("fp_pc_const", d_pc, 32'h4);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        check_all("fp_drain");

        // Flush while full with concurrent push and pop.
        cycle(1'b0, 1'b0, 1'b1, 32'h10, 32'h14, 32'h77777777, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h14, 32'h18, 32'h88888888, 1'b0);
        check_all("fl_full");
        cycle(1'b0, 1'b1, 1'b1, 32'h100, 32'h104, 32'h99999999, 1'b1);
        check_all("fl_flush");
        chk("fl_count_const", 32'(count), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h40, 32'h44, 32'hAAAAAAAA, 1'b0);
        check_all("fl_redirect");
        chk("fl_pc_const", d_pc, 32'h40);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        check_all("fl_drain");

        // Wrap-around: 8 sequential PCs with random Decode stalls.
        got_pc.delete();
        got_p4.delete();
        idx = 0;
        for (int c = 0; c < 200 && got_pc.size() < 8; c++) begin
            bit fv, dr, acc;
            fv  = (idx < 8);
            dr  = 1'($urandom_range(0, 1));
            acc = fv && (model_q.size() < DEPTH);
            cycle(1'b0, 1'b0, fv, 32'(idx * 4), 32'(idx * 4 + 4),
                  32'h00000013 | 32'(idx << 20), dr);
            if (acc) idx++;
            check_all("wrap");
        end
        chk("wrap_n", 32'(got_pc.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_pc", (i < got_pc.size()) ? got_pc[i] : 32'hFFFFFFFF, 32'(i * 4));
            chk("wrap_p4", (i < got_p4.size()) ? got_p4[i] : 32'hFFFFFFFF, 32'(i * 4 + 4));
        end

        // Random traffic including occasional flush and reset.
        for (int c = 0; c < 300; c++) begin
            logic [31:0] pc;
            pc = $urandom;
            cycle(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 1)), pc, pc + 32'd4, $urandom,
                  1'($urandom_range(0, 1)));
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
